// File: rtl/tag_router_pkg.sv
// tag_router_pkg: shared state encodings, default parameters and lane unpacking helper.
package tag_router_pkg;
  localparam int DEF_NUM_CH = 13;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_TAG_W = 4;
  localparam int DEF_HOLD_MODE = 0;
  localparam int DEF_CNT_W = 16;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ROUTE = 1'b1;
  function automatic int lane_lsb(input int lane, input int tag_w, input int data_w);
    return lane * (tag_w + data_w);
  endfunction
endpackage

// File: rtl/tag_router_arb.sv
// tag_router_arb: lowest-lane priority select of pending lanes addressed to one destination slot.
module tag_router_arb import tag_router_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int TAG_W = DEF_TAG_W,
  parameter int SLOT = 0
) (
  input  logic [NUM_CH-1:0]       pend_i,
  input  logic [NUM_CH*TAG_W-1:0] tags_i,
  output logic [NUM_CH-1:0]       win_o,
  output logic                    hit_o
);
  localparam logic [TAG_W-1:0] TAG = TAG_W'(SLOT + 1);
  logic [NUM_CH-1:0] match;
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_CH; i++) match[i] = pend_i[i] && tags_i[i*TAG_W +: TAG_W] == TAG;
  end
  assign win_o = match & (-match);
  assign hit_o = |match;
endmodule

// File: rtl/tag_router.sv
// tag_router: registered tag-steered lane router; collisions replay in later beats, lowest lane first.
module tag_router import tag_router_pkg::*; #(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W = DEF_TAG_W,
  parameter int HOLD_MODE = DEF_HOLD_MODE,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_CH*(TAG_W+DATA_W)-1:0] in_data,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [NUM_CH*DATA_W-1:0]         out_data,
  output logic [NUM_CH-1:0]                out_mask,
  output logic                             err_tag,
  output logic [CNT_W-1:0]                 coll_cnt
);
  localparam logic [TAG_W-1:0] MAX_TAG = TAG_W'(NUM_CH);
  if (2**TAG_W <= NUM_CH) begin : g_bad_tag_w
    $error("tag_router: TAG_W too narrow to address NUM_CH slots");
  end
  logic [0:0] state_q, state_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0][TAG_W-1:0] tag_q, tag_d;
  logic [NUM_CH-1:0][DATA_W-1:0] pay_q, pay_d;
  logic ov_q, ov_d;
  logic [NUM_CH-1:0][DATA_W-1:0] od_q, od_d;
  logic [NUM_CH-1:0] om_q, om_d;
  logic err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0][TAG_W-1:0] in_tag;
  logic [NUM_CH-1:0][DATA_W-1:0] in_pay;
  logic [NUM_CH-1:0] in_ok, in_bad;
  logic [NUM_CH-1:0][NUM_CH-1:0] win;
  logic [NUM_CH-1:0] hit, clr;
  logic [NUM_CH-1:0][DATA_W-1:0] slot_pay;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    assign in_tag[i] = in_data[lane_lsb(i, TAG_W, DATA_W) + DATA_W +: TAG_W];
    assign in_pay[i] = in_data[lane_lsb(i, TAG_W, DATA_W) +: DATA_W];
    assign in_ok[i] = in_tag[i] != '0 && in_tag[i] <= MAX_TAG;
    assign in_bad[i] = in_tag[i] > MAX_TAG;
  end
  for (genvar j = 0; j < NUM_CH; j++) begin : g_arb
    tag_router_arb #(.NUM_CH(NUM_CH), .TAG_W(TAG_W), .SLOT(j)) u_arb (
      .pend_i(pend_q),
      .tags_i(tag_q),
      .win_o (win[j]),
      .hit_o (hit[j])
    );
  end
  always_comb begin
    clr = '0;
    slot_pay = '0;
    for (int j = 0; j < NUM_CH; j++) begin
      clr |= win[j];
      for (int i = 0; i < NUM_CH; i++) slot_pay[j] |= win[j][i] ? pay_q[i] : '0;
    end
  end
  always_comb begin
    state_d = state_q;
    pend_d = pend_q;
    tag_d = tag_q;
    pay_d = pay_q;
    ov_d = ov_q && !out_ready;
    od_d = od_q;
    om_d = om_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (state_q == IDLE && in_valid) begin
      tag_d = in_tag;
      pay_d = in_pay;
      pend_d = in_ok;
      err_d = err_q | (|in_bad);
      state_d = |in_ok ? ROUTE : IDLE;
    end
    if (state_q == ROUTE && (!ov_q || out_ready)) begin
      for (int j = 0; j < NUM_CH; j++) od_d[j] = hit[j] ? slot_pay[j] : (HOLD_MODE != 0 ? od_q[j] : '0);
      om_d = hit;
      ov_d = 1'b1;
      pend_d = pend_q & ~clr;
      cnt_d = (|pend_d && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
      state_d = |pend_d ? ROUTE : IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q <= '0;
      tag_q <= '0;
      pay_q <= '0;
      ov_q <= 1'b0;
      od_q <= '0;
      om_q <= '0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      tag_q <= tag_d;
      pay_q <= pay_d;
      ov_q <= ov_d;
      od_q <= od_d;
      om_q <= om_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = state_q == IDLE && !rst;
  assign out_valid = ov_q;
  assign out_data = od_q;
  assign out_mask = om_q;
  assign err_tag = err_q;
  assign coll_cnt = cnt_q;
endmodule

// File: tb/tb_tag_router.sv
// tb_tag_router: table-driven vectors plus backpressure/reset sequences, checked by a beat scoreboard.
module tb_tag_router;
  localparam int N = 13;
  localparam int DW = 16;
  localparam int TW = 4;
  localparam int CW = 16;
  typedef struct packed {
    logic [N-1:0][DW-1:0] d0;
    logic [N-1:0][DW-1:0] d1;
    logic [N-1:0] m;
  } beat_t;
  typedef struct packed {
    logic [N-1:0][TW-1:0] tg;
    logic [N-1:0][DW-1:0] py;
    logic [7:0] beats;
    logic err;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [N*(TW+DW)-1:0] in_data = '0;
  logic ir0, ov0, err0, ir1, ov1, err1;
  logic [N*DW-1:0] od0, od1;
  logic [N-1:0] om0, om1;
  logic [CW-1:0] cnt0, cnt1;
  beat_t sb[$];
  beat_t mb;
  logic [N-1:0][DW-1:0] hold1 = '0;
  vec_t vecs[7];
  int ncmp = 0;
  int nfail = 0;
  int beats_seen = 0;
  int exp_cnt = 0;
  int b0;
  logic [N-1:0][TW-1:0] tg;
  logic [N-1:0][DW-1:0] py;
  always #5 clk = ~clk;
  tag_router #(.HOLD_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_mask(om0),
    .err_tag(err0), .coll_cnt(cnt0)
  );
  tag_router #(.HOLD_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_mask(om1),
    .err_tag(err1), .coll_cnt(cnt1)
  );
  task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask
  function automatic void model(input logic [N-1:0][TW-1:0] t, input logic [N-1:0][DW-1:0] p);
    logic [N-1:0] pend;
    beat_t b;
    for (int i = 0; i < N; i++) pend[i] = int'(t[i]) != 0 && int'(t[i]) <= N;
    while (pend != '0) begin
      b = '0;
      for (int j = 0; j < N; j++)
        for (int i = 0; i < N; i++)
          if (pend[i] && int'(t[i]) == j + 1 && !b.m[j]) begin
            b.m[j] = 1'b1;
            b.d0[j] = p[i];
            pend[i] = 1'b0;
          end
      for (int j = 0; j < N; j++) if (b.m[j]) hold1[j] = b.d0[j];
      b.d1 = hold1;
      sb.push_back(b);
    end
  endfunction
  task automatic send(input logic [N-1:0][TW-1:0] t, input logic [N-1:0][DW-1:0] p);
    int n = 0;
    for (int i = 0; i < N; i++) in_data[i*(TW+DW) +: TW+DW] = {t[i], p[i]};
    in_valid = 1'b1;
    while (!ir0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ir0) begin
      ncmp++;
      nfail++;
      $display("FAIL send_timeout: in_ready 0 after %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model(t, p);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !ir0 || ov0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      ncmp++;
      nfail++;
      $display("FAIL drain_timeout: %0d beats still expected after %0d cycles, required 0", sb.size(), n);
    end
  endtask
  task automatic wait_valid();
    int n = 0;
    @(negedge clk);
    while (!ov0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_out_valid", 256'(ov0), 256'(1));
  endtask
  always @(negedge clk) begin
    if (!rst && ov0 && out_ready) begin
      beats_seen++;
      if (sb.size() == 0) begin
        ncmp++;
        nfail++;
        $display("FAIL unexpected_beat: got beat with mask %0h, required no beat", om0);
      end else begin
        mb = sb.pop_front();
        check("beat_mask_h0", 256'(om0), 256'(mb.m));
        check("beat_data_h0", 256'(od0), 256'(mb.d0));
        check("beat_mask_h1", 256'(om1), 256'(mb.m));
        check("beat_data_h1", 256'(od1), 256'(mb.d1));
        check("beat_valid_h1", 256'(ov1), 256'(1));
      end
    end
  end
  initial begin
    for (int k = 0; k < 7; k++) vecs[k] = '0;
    for (int i = 0; i < N; i++) begin
      vecs[0].tg[i] = 4'(13 - i);
      vecs[0].py[i] = 16'(32'h1000 + i);
      vecs[4].tg[i] = 4'(i % 3 + 1);
      vecs[4].py[i] = 16'(32'h2000 + i);
      vecs[5].tg[i] = 4'd13;
      vecs[5].py[i] = 16'(32'h3000 + i);
    end
    vecs[0].beats = 8'd1;
    vecs[1].tg[2] = 4'd4; vecs[1].py[2] = 16'h000A;
    vecs[1].tg[5] = 4'd4; vecs[1].py[5] = 16'h000B;
    vecs[1].tg[9] = 4'd4; vecs[1].py[9] = 16'h000C;
    vecs[1].beats = 8'd3;
    vecs[3].tg[0] = 4'd15; vecs[3].py[0] = 16'h00EE;
    vecs[3].tg[1] = 4'd1; vecs[3].py[1] = 16'h0055;
    vecs[3].beats = 8'd1; vecs[3].err = 1'b1;
    vecs[4].beats = 8'd5; vecs[4].err = 1'b1;
    vecs[5].beats = 8'd13; vecs[5].err = 1'b1;
    vecs[6].tg[5] = 4'd14; vecs[6].py[5] = 16'h0077;
    vecs[6].err = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cycle_in_ready", 256'(ir0), 256'(0));
    check("rst_cycle_out_valid", 256'(ov0), 256'(0));
    rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 256'(ir0), 256'(1));
    check("reset_out_valid", 256'(ov0), 256'(0));
    check("reset_out_mask", 256'(om0), 256'(0));
    check("reset_out_data", 256'(od0), 256'(0));
    check("reset_err_tag", 256'(err0), 256'(0));
    check("reset_coll_cnt", 256'(cnt0), 256'(0));
    for (int k = 0; k < 7; k++) begin
      b0 = beats_seen;
      @(posedge clk);
      #1;
      send(vecs[k].tg, vecs[k].py);
      check($sformatf("vec%0d_in_ready_after_accept", k), 256'(ir0), 256'(vecs[k].beats == 8'd0));
      drain();
      exp_cnt += vecs[k].beats > 8'd0 ? int'(vecs[k].beats) - 1 : 0;
      check($sformatf("vec%0d_beats", k), 256'(beats_seen - b0), 256'(vecs[k].beats));
      check($sformatf("vec%0d_err_tag", k), 256'(err0), 256'(vecs[k].err));
      check($sformatf("vec%0d_coll_cnt", k), 256'(cnt0), 256'(exp_cnt));
      if (k == 0) begin
        check("perm_mask", 256'(om0), 256'(13'h1FFF));
        check("perm_slot0", 256'(od0[0 +: 16]), 256'(16'h100C));
        check("perm_slot12", 256'(od0[12*16 +: 16]), 256'(16'h1000));
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    tg = '0;
    py = '0;
    tg[0] = 4'd2; py[0] = 16'h0011;
    tg[1] = 4'd2; py[1] = 16'h0022;
    tg[3] = 4'd5; py[3] = 16'h0033;
    send(tg, py);
    wait_valid();
    for (int c = 0; c < 5; c++) begin
      check("stall_mask", 256'(om0), 256'(13'h0012));
      check("stall_slot1", 256'(od0[1*16 +: 16]), 256'(16'h0011));
      check("stall_slot4", 256'(od0[4*16 +: 16]), 256'(16'h0033));
      check("stall_in_ready", 256'(ir0), 256'(0));
      check("stall_out_valid", 256'(ov0), 256'(1));
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();
    exp_cnt += 1;
    check("stall_coll_cnt", 256'(cnt0), 256'(exp_cnt));
    check("replay_slot1_h0", 256'(od0[1*16 +: 16]), 256'(16'h0022));
    check("replay_slot4_h0", 256'(od0[4*16 +: 16]), 256'(16'h0000));
    check("replay_slot4_h1", 256'(od1[4*16 +: 16]), 256'(16'h0033));
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(vecs[1].tg, vecs[1].py);
    wait_valid();
    check("pre_rst_in_ready", 256'(ir0), 256'(0));
    check("pre_rst_coll_cnt", 256'(cnt0), 256'(exp_cnt + 1));
    check("pre_rst_err_tag", 256'(err0), 256'(1));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    hold1 = '0;
    b0 = beats_seen;
    @(negedge clk);
    check("mid_rst_out_valid", 256'(ov0), 256'(0));
    check("mid_rst_coll_cnt", 256'(cnt0), 256'(0));
    check("mid_rst_err_tag", 256'(err0), 256'(0));
    check("mid_rst_out_mask", 256'(om0), 256'(0));
    check("mid_rst_out_data", 256'(od0), 256'(0));
    check("mid_rst_in_ready", 256'(ir0), 256'(1));
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_rst_no_beats", 256'(beats_seen - b0), 256'(0));
    check("scoreboard_empty", 256'(sb.size()), 256'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
